// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults, a 1024x768@60 preset,
// sync polarity codes, the raster state type and a width helper.
package vga_timing_pkg;

  typedef enum logic {
    ST_PREROLL = 1'b0,
    ST_RUN     = 1'b1
  } vga_state_t;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // 640x480@60, 25.175 MHz pixel clock, 800x525 totals
  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;
  localparam int VGA640_H_TOTAL   = VGA640_H_VISIBLE + VGA640_H_FRONT + VGA640_H_SYNC + VGA640_H_BACK;
  localparam int VGA640_V_TOTAL   = VGA640_V_VISIBLE + VGA640_V_FRONT + VGA640_V_SYNC + VGA640_V_BACK;
  localparam bit VGA640_HSYNC_POL = SYNC_ACTIVE_LOW;
  localparam bit VGA640_VSYNC_POL = SYNC_ACTIVE_LOW;

  // 1024x768@60, 65 MHz pixel clock, 1344x806 totals
  localparam int XGA1024_H_VISIBLE = 1024;
  localparam int XGA1024_H_FRONT   = 24;
  localparam int XGA1024_H_SYNC    = 136;
  localparam int XGA1024_H_BACK    = 160;
  localparam int XGA1024_V_VISIBLE = 768;
  localparam int XGA1024_V_FRONT   = 3;
  localparam int XGA1024_V_SYNC    = 6;
  localparam int XGA1024_V_BACK    = 29;
  localparam int XGA1024_H_TOTAL   = XGA1024_H_VISIBLE + XGA1024_H_FRONT + XGA1024_H_SYNC + XGA1024_H_BACK;
  localparam int XGA1024_V_TOTAL   = XGA1024_V_VISIBLE + XGA1024_V_FRONT + XGA1024_V_SYNC + XGA1024_V_BACK;
  localparam bit XGA1024_HSYNC_POL = SYNC_ACTIVE_LOW;
  localparam bit XGA1024_VSYNC_POL = SYNC_ACTIVE_LOW;

  // Bits needed to hold 0..v-1, never less than one (so CLK_DIV=1 still gets a register).
  function automatic int bits_for(input int v);
    int b;
    b = 1;
    while ((1 << b) < v) b++;
    return b;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo position counter whose sync and visible flags are
// computed from the next position, so all three registers always agree.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter bit POL     = 1'b0,
  parameter int W       = $clog2(VISIBLE + FRONT + SYNC + BACK)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load_zero,
  input  logic         step,
  output logic [W-1:0] pos,
  output logic         sync,
  output logic         active,
  output logic         at_last
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
  localparam logic [W:0]   VIS_END    = (W+1)'(VISIBLE);
  localparam logic [W:0]   SYNC_START = (W+1)'(VISIBLE + FRONT);
  localparam logic [W:0]   SYNC_END   = (W+1)'(VISIBLE + FRONT + SYNC);

  logic [W-1:0] pos_reg;
  logic [W-1:0] pos_next;
  logic         sync_reg;
  logic         sync_next;
  logic         active_reg;
  logic         active_next;
  logic         upd;

  assign at_last = (pos_reg == LAST);
  assign upd     = load_zero | step;

  always_comb begin
    pos_next = pos_reg;
    if (load_zero) begin
      pos_next = '0;
    end else if (step) begin
      pos_next = at_last ? '0 : pos_reg + W'(1);
    end
    // Window compares are one bit wider so a window ending at TOTAL cannot overflow.
    active_next = ({1'b0, pos_next} < VIS_END);
    sync_next   = (({1'b0, pos_next} >= SYNC_START) && ({1'b0, pos_next} < SYNC_END)) ? POL : ~POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_reg    <= '0;
      sync_reg   <= ~POL;
      active_reg <= 1'b0;
    end else if (clr) begin
      pos_reg    <= '0;
      sync_reg   <= ~POL;
      active_reg <= 1'b0;
    end else if (upd) begin
      pos_reg    <= pos_next;
      sync_reg   <= sync_next;
      active_reg <= active_next;
    end
  end

  assign pos    = pos_reg;
  assign sync   = sync_reg;
  assign active = active_reg;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel prescaler, enable freeze,
// synchronous restart to pre-roll and a completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = VGA640_H_VISIBLE,
  parameter int H_FRONT   = VGA640_H_FRONT,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BACK    = VGA640_H_BACK,
  parameter int V_VISIBLE = VGA640_V_VISIBLE,
  parameter int V_FRONT   = VGA640_V_FRONT,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BACK    = VGA640_V_BACK,
  parameter bit HSYNC_POL = VGA640_HSYNC_POL,
  parameter bit VSYNC_POL = VGA640_VSYNC_POL,
  parameter int CLK_DIV   = 1,
  parameter int FC_W      = 8,
  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int H_W      = $clog2(H_TOTAL),
  localparam int V_W      = $clog2(V_TOTAL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            restart,
  output logic [H_W-1:0]  hpos,
  output logic [V_W-1:0]  vpos,
  output logic            hsync,
  output logic            vsync,
  output logic            visible,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int P_W = bits_for(CLK_DIV);
  localparam logic [P_W-1:0] PRESC_LAST = P_W'(CLK_DIV - 1);

  vga_state_t      state_reg;
  vga_state_t      state_next;
  logic [P_W-1:0]  presc_reg;
  logic            tick;
  logic            h_load;
  logic            h_step;
  logic            v_step;
  logic            h_last;
  logic            v_last;
  logic            h_active;
  logic            v_active;
  logic            line_start_reg;
  logic            line_start_next;
  logic            frame_start_reg;
  logic            frame_start_next;
  logic            fc_inc;
  logic [FC_W-1:0] frame_count_reg;

  assign tick = ena && (presc_reg == PRESC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (restart) begin
      presc_reg <= '0;
    end else if (ena) begin
      presc_reg <= tick ? '0 : presc_reg + P_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_PREROLL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    h_load           = 1'b0;
    h_step           = 1'b0;
    v_step           = 1'b0;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;
    fc_inc           = 1'b0;
    case (state_reg)
      ST_PREROLL: begin
        if (tick) begin
          state_next       = ST_RUN;
          h_load           = 1'b1;
          line_start_next  = 1'b1;
          frame_start_next = 1'b1;
        end
      end
      ST_RUN: begin
        if (tick) begin
          h_step           = 1'b1;
          v_step           = h_last;
          line_start_next  = h_last;
          frame_start_next = h_last && v_last;
          fc_inc           = h_last && v_last;
        end
      end
      default: state_next = ST_PREROLL;
    endcase
    // Restart overrides any tick arriving in the same cycle.
    if (restart) begin
      state_next       = ST_PREROLL;
      h_load           = 1'b0;
      h_step           = 1'b0;
      v_step           = 1'b0;
      line_start_next  = 1'b0;
      frame_start_next = 1'b0;
      fc_inc           = 1'b0;
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HSYNC_POL),
    .W       (H_W)
  ) u_h_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (restart),
    .load_zero (h_load),
    .step      (h_step),
    .pos       (hpos),
    .sync      (hsync),
    .active    (h_active),
    .at_last   (h_last)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VSYNC_POL),
    .W       (V_W)
  ) u_v_axis (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (restart),
    .load_zero (h_load),
    .step      (v_step),
    .pos       (vpos),
    .sync      (vsync),
    .active    (v_active),
    .at_last   (v_last)
  );

  // Strobes are rewritten every clk so they never outlast a single cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= '0;
    end else begin
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      if (restart) begin
        frame_count_reg <= '0;
      end else if (fc_inc) begin
        frame_count_reg <= frame_count_reg + FC_W'(1);
      end
    end
  end

  assign visible     = h_active & v_active;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_count = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a 14x7 raster: divide-by-1/3,
// inverted polarity, random enable, restart and asynchronous reset.
module tb_vga_timing_gen;

  typedef struct {
    int cyc;
    int h;
    int v;
    bit hs;
    bit vs;
    bit vis;
    bit ls;
    bit fs;
    int fc;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena_a = 1'b0, restart_a = 1'b0;
  logic       ena_b = 1'b0, restart_b = 1'b0;
  logic       ena_c = 1'b0, restart_c = 1'b0;

  logic [3:0] hpos_a, hpos_b, hpos_c;
  logic [2:0] vpos_a, vpos_b, vpos_c;
  logic       hs_a, vs_a, vis_a, ls_a, fs_a;
  logic       hs_b, vs_b, vis_b, ls_b, fs_b;
  logic       hs_c, vs_c, vis_c, ls_c, fs_c;
  logic [1:0] fc_a;
  logic [7:0] fc_b, fc_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(1), .FC_W(2)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena_a), .restart(restart_a),
    .hpos(hpos_a), .vpos(vpos_a), .hsync(hs_a), .vsync(vs_a), .visible(vis_a),
    .line_start(ls_a), .frame_start(fs_a), .frame_count(fc_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(3), .FC_W(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena_b), .restart(restart_b),
    .hpos(hpos_b), .vpos(vpos_b), .hsync(hs_b), .vsync(vs_b), .visible(vis_b),
    .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(1), .FC_W(8)
  ) dut_c (
    .clk(clk), .rst_n(rst_n), .ena(ena_c), .restart(restart_c),
    .hpos(hpos_c), .vpos(vpos_c), .hsync(hs_c), .vsync(vs_c), .visible(vis_c),
    .line_start(ls_c), .frame_start(fs_c), .frame_count(fc_c)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s 0x%0h", name, act);
    end
  endtask

  // {hpos,vpos,hsync,vsync,visible,line_start,frame_start,frame_count}
  function automatic int pk(input int h, input int v, input bit hs, input bit vs,
                            input bit vis, input bit ls, input bit fs, input int fc);
    logic [3:0] hh;
    logic [2:0] vv;
    logic [1:0] ff;
    hh = 4'(h);
    vv = 3'(v);
    ff = 2'(fc);
    return int'({hh, vv, hs, vs, vis, ls, fs, ff});
  endfunction

  function automatic int act_a();
    return int'({hpos_a, vpos_a, hs_a, vs_a, vis_a, ls_a, fs_a, fc_a});
  endfunction

  // Expected A-geometry outputs for the n-th pixel after the pre-roll tick.
  function automatic int model_a(input int n, input bit ticked);
    int h, v;
    h = n % 14;
    v = (n / 14) % 7;
    return pk(h, v, !(h >= 10 && h < 12), !(v == 5), (h < 8) && (v < 4),
              ticked && h == 0, ticked && h == 0 && v == 0, (n / 98) % 4);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tbl[17];
  int   rst_pk;

  initial begin
    int ti;
    int en_cnt;
    int fs_seen;
    int fc_exp[5];
    fc_exp = '{1, 2, 3, 0, 1};
    rst_pk = pk(0, 0, 1, 1, 0, 0, 0, 0);

    tbl[0]  = '{0,  0, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1,  0, 0, 1, 1, 1, 1, 1, 0};
    tbl[2]  = '{2,  1, 0, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{8,  7, 0, 1, 1, 1, 0, 0, 0};
    tbl[4]  = '{9,  8, 0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{10, 9, 0, 1, 1, 0, 0, 0, 0};
    tbl[6]  = '{11, 10, 0, 0, 1, 0, 0, 0, 0};
    tbl[7]  = '{12, 11, 0, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{13, 12, 0, 1, 1, 0, 0, 0, 0};
    tbl[9]  = '{14, 13, 0, 1, 1, 0, 0, 0, 0};
    tbl[10] = '{15, 0, 1, 1, 1, 1, 1, 0, 0};
    tbl[11] = '{57, 0, 4, 1, 1, 0, 1, 0, 0};
    tbl[12] = '{71, 0, 5, 1, 0, 0, 1, 0, 0};
    tbl[13] = '{81, 10, 5, 0, 0, 0, 0, 0, 0};
    tbl[14] = '{85, 0, 6, 1, 1, 0, 1, 0, 0};
    tbl[15] = '{98, 13, 6, 1, 1, 0, 0, 0, 0};
    tbl[16] = '{99, 0, 0, 1, 1, 1, 1, 1, 1};

    // Reset state, then 300 free-running clks on all three instances.
    ena_a = 1'b1; ena_b = 1'b1; ena_c = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("a_reset", act_a(), pk(tbl[0].h, tbl[0].v, tbl[0].hs, tbl[0].vs, tbl[0].vis,
                               tbl[0].ls, tbl[0].fs, tbl[0].fc));
    chk("c_reset_sync", int'({hs_c, vs_c}), 0);
    rst_n = 1'b1;
    ti = 1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (ti < 17 && tbl[ti].cyc == k) begin
        chk($sformatf("a_vec_clk%0d", k), act_a(),
            pk(tbl[ti].h, tbl[ti].v, tbl[ti].hs, tbl[ti].vs, tbl[ti].vis,
               tbl[ti].ls, tbl[ti].fs, tbl[ti].fc));
        ti++;
      end
      begin
        int n, h, v, fc;
        bit st;
        if (k < 3) begin
          h = 0; v = 0; st = 1'b0; fc = 0;
        end else begin
          n  = k / 3 - 1;
          h  = n % 14;
          v  = (n / 14) % 7;
          st = (k % 3 == 0) && (h == 0);
          fc = (n / 98) % 256;
        end
        if (k <= 20 || k % 25 == 0 || (k >= 294 && k <= 299)) begin
          chk($sformatf("b_div3_clk%0d", k), int'({hpos_b, vpos_b, ls_b, fs_b, fc_b}),
              int'({4'(h), 3'(v), st, st && (v == 0), 8'(fc)}));
        end
      end
      if (k == 1)  chk("c_pol_clk1",  int'({hs_c, vs_c}), 0);
      if (k == 11) chk("c_pol_clk11", int'({hs_c, vs_c}), 2);
      if (k == 71) chk("c_pol_clk71", int'({hs_c, vs_c}), 1);
    end
    if (ti != 17) chk("a_table_consumed", ti, 17);

    // Restart at (5,3) of the second frame with ena=1.
    do_reset();
    for (int k = 1; k <= 146; k++) @(negedge clk);
    chk("rs_before", act_a(), pk(5, 3, 1, 1, 1, 0, 0, 1));
    restart_a = 1'b1;
    @(negedge clk);
    chk("rs_reset_vals", act_a(), rst_pk);
    restart_a = 1'b0;
    @(negedge clk);
    chk("rs_first_pixel", act_a(), pk(0, 0, 1, 1, 1, 1, 1, 0));

    // Random ena: sequence must match the free-running raster, only stretched.
    do_reset();
    en_cnt = 0;
    for (int k = 0; k < 400; k++) begin
      bit e;
      e = 1'($urandom_range(0, 1));
      ena_a = e;
      @(negedge clk);
      if (e) en_cnt++;
      chk($sformatf("ena_clk%0d", k), act_a(),
          (en_cnt == 0) ? rst_pk : model_a(en_cnt - 1, e));
    end
    ena_a = 1'b1;

    // Asynchronous reset between clk edges, then 5 frames on the 2-bit counter.
    for (int k = 0; k < 20; k++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", act_a(), rst_pk);
    @(negedge clk);
    rst_n = 1'b1;
    fs_seen = 0;
    for (int k = 0; k < 5 * 98 + 20 && fs_seen < 6; k++) begin
      @(negedge clk);
      if (fs_a) begin
        if (fs_seen > 0) chk($sformatf("fc_frame%0d", fs_seen), int'(fc_a), fc_exp[fs_seen - 1]);
        fs_seen++;
      end
    end
    if (fs_seen < 6) chk("frames_seen", fs_seen, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: produces pixel coordinates, sync pulses, visibility and line/frame strobes for the pixel-generation logic in the TinyTapeout top-level. It replaces hard-coded 640x480 counters with a generalised block supporting any porch/sync geometry, sync polarity, a pixel-clock prescaler, a clock-enable freeze, a synchronous restart and a frame counter.

## Interface
Parameters:
- H_VISIBLE, 640: visible pixels per line
- H_FRONT, 16: horizontal front porch (pixels)
- H_SYNC, 96: hsync width (pixels)
- H_BACK, 48: horizontal back porch (pixels)
- V_VISIBLE, 480: visible lines per frame
- V_FRONT, 10: vertical front porch (lines)
- V_SYNC, 2: vsync width (lines)
- V_BACK, 33: vertical back porch (lines)
- HSYNC_POL, 0: active level of hsync (0 = active-low)
- VSYNC_POL, 0: active level of vsync
- CLK_DIV, 1: clk cycles per pixel (≥1)
- FC_W, 8: frame counter width
- Derived: H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, H_W = $clog2(H_TOTAL), V_W = $clog2(V_TOTAL)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  advance enable; low freezes all state
- restart  in  1  synchronous return to pre-roll
- hpos  out  H_W  current pixel column
- vpos  out  V_W  current line
- hsync  out  1  horizontal sync, polarity HSYNC_POL
- vsync  out  1  vertical sync, polarity VSYNC_POL
- visible  out  1  hpos < H_VISIBLE and vpos < V_VISIBLE
- line_start  out  1  one-clk pulse when hpos enters 0
- frame_start  out  1  one-clk pulse when (hpos,vpos) enters (0,0)
- frame_count  out  FC_W  completed-frame count, modulo 2^FC_W

## Operation
- Clock and reset: one clock, clk; rst_n asynchronous, active-low.
- States: PREROLL (after reset/restart) and RUN. PREROLL → RUN on first pixel tick.
- Pixel tick: prescaler counts 0..CLK_DIV-1 while ena=1; tick when prescaler = CLK_DIV-1 (CLK_DIV=1: every ena cycle). ena=0 holds prescaler and all outputs; strobes forced 0.
- On tick in PREROLL: load (0,0), visible=1, line_start=frame_start=1, frame_count unchanged (0).
- On tick in RUN: hpos+1; at H_TOTAL-1 wraps to 0, pulses line_start, vpos+1; vpos at V_TOTAL-1 wraps to 0 with frame_start pulse and frame_count+1 (wraps at 2^FC_W).
- hsync active iff H_VISIBLE+H_FRONT ≤ hpos < H_VISIBLE+H_FRONT+H_SYNC; vsync active iff same rule on vpos with V_* (whole lines).
- All outputs registered and mutually consistent: hsync/vsync/visible describe the pixel currently on hpos/vpos.
- restart=1: next clk returns to PREROLL with reset values (prescaler cleared, frame_count cleared); restart wins over ena/tick in same cycle.
- Reset mid-frame: all outputs go to reset values immediately, asynchronously.

## Timing
- Reset values: hpos=0, vpos=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, visible=0, line_start=0, frame_start=0, frame_count=0, state PREROLL, prescaler 0.
- Latency: outputs update on the clk edge of the tick; first (0,0) appears CLK_DIV enabled clks after reset release.
- Strobes last exactly one clk regardless of CLK_DIV.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV enabled clks.

## Structure
- Shared package vga_timing_pkg: default 640x480@60 constants (800x525 totals), polarity constants, a second 1024x768 preset.
- One sub-module natural: vga_axis_counter (modulo counter with sync-window and visible compare), instantiated for H and V; H wrap drives V increment.

## Test plan
- Small geometry H=8/2/2/2 (14), V=4/1/1/1 (7), CLK_DIV=1: after rst_n release, first clk gives (0,0), frame_start=1; hsync low exactly for hpos 10–11; vsync low for vpos 5; next frame_start 98 clks later, frame_count=1.
- CLK_DIV=3, same geometry: hpos increments every 3rd clk; line_start width 1 clk; frame period 294 clks.
- ena toggled 1/0 pseudo-randomly: sequence of (hpos,vpos) identical to ena=1 run, only stretched; no strobes while ena=0.
- restart asserted at (5,3) with ena=1: next clk outputs reset values, following clk (0,0) with frame_start=1, frame_count=0.
- Async rst_n pulse mid-line (no clk edge): outputs reach reset values immediately; FC_W=2 run of 5 frames shows frame_count 1,2,3,0,1.
- HSYNC_POL=1, VSYNC_POL=1: sync levels inverted, reset levels 0.
